// File: rtl/rom_loader.sv
// UART boot loader for the Hack instruction ROM: snoops the rx byte stream for a sync byte,
// writes a length-prefixed, XOR-checksummed program into the ROM and replies 'K' or 'E'.
module rom_loader #(
    parameter int         ADDR_WIDTH     = 15,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 27_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [15:0]           rom_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  loaded,
    output logic                  error
);

    localparam logic [7:0]      ACK        = 8'h4B;
    localparam logic [7:0]      NAK        = 8'h45;
    localparam int              TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]     CAPACITY   = 17'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_RUN, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_REPLY, S_HALT
    } state_t;

    state_t                  state;
    logic [7:0]              len_hi;
    logic [7:0]              data_hi;
    logic [7:0]              chk;
    logic [15:0]             remaining;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [TW-1:0]           idle;
    logic                    reply_ok;

    logic        sync_seen;
    logic [15:0] count;
    logic        oversize;

    assign sync_seen = rx_valid && (rx_data == SYNC_BYTE);
    assign count     = {len_hi, rx_data};
    assign oversize  = {1'b0, count} > CAPACITY;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_RUN;
            cpu_reset <= 1'b1;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_wdata <= 16'h0000;
            busy      <= 1'b0;
            loaded    <= 1'b0;
            error     <= 1'b0;
            reply_ok  <= 1'b0;
            chk       <= 8'h00;
            idle      <= '0;
        end else begin
            rom_we <= 1'b0;
            unique case (state)
                S_RUN, S_HALT: begin
                    if (sync_seen) begin
                        state     <= S_LEN_HI;
                        cpu_reset <= 1'b1;
                        busy      <= 1'b1;
                        error     <= 1'b0;
                        chk       <= 8'h00;
                        idle      <= '0;
                    end else if (state == S_RUN) begin
                        cpu_reset <= 1'b0;
                    end
                end
                // Reply is held until accepted; rx bytes (even SYNC) are ignored here.
                S_REPLY: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        if (reply_ok) begin
                            state     <= S_RUN;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= S_HALT;
                        end
                    end
                end
                default: begin
                    if (rx_valid) begin
                        idle <= '0;
                        chk  <= chk ^ rx_data;
                        case (state)
                            S_LEN_HI: begin
                                len_hi <= rx_data;
                                state  <= S_LEN_LO;
                            end
                            S_LEN_LO: begin
                                addr      <= '0;
                                remaining <= count;
                                if (count == 16'd0) begin
                                    state <= S_CHECK;
                                end else if (oversize) begin
                                    state    <= S_REPLY;
                                    tx_valid <= 1'b1;
                                    tx_data  <= NAK;
                                    reply_ok <= 1'b0;
                                    error    <= 1'b1;
                                end else begin
                                    state <= S_DATA_HI;
                                end
                            end
                            S_DATA_HI: begin
                                data_hi <= rx_data;
                                state   <= S_DATA_LO;
                            end
                            S_DATA_LO: begin
                                rom_we    <= 1'b1;
                                rom_addr  <= addr;
                                rom_wdata <= {data_hi, rx_data};
                                addr      <= addr + ADDR_WIDTH'(1);
                                remaining <= remaining - 16'd1;
                                state     <= (remaining == 16'd1) ? S_CHECK : S_DATA_HI;
                            end
                            S_CHECK: begin
                                state    <= S_REPLY;
                                tx_valid <= 1'b1;
                                if (rx_data == chk) begin
                                    tx_data  <= ACK;
                                    reply_ok <= 1'b1;
                                    loaded   <= 1'b1;
                                end else begin
                                    tx_data  <= NAK;
                                    reply_ok <= 1'b0;
                                    error    <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end else if (idle == IDLE_LIMIT) begin
                        state    <= S_REPLY;
                        tx_valid <= 1'b1;
                        tx_data  <= NAK;
                        reply_ok <= 1'b0;
                        error    <= 1'b1;
                    end else begin
                        idle <= idle + TW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Randomized bench for rom_loader: frames are scored against a frame-level model of the
// expected ROM writes, reply byte and status flags.
module tb_rom_loader;

    localparam int AW  = 4;
    localparam int TMO = 100;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          tx_ready = 1'b0;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          loaded;
    logic          error;

    always #5 clk = ~clk;

    rom_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .loaded(loaded), .error(error)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]        frame_q[$];
    logic [AW+15:0]    exp_wr[$];
    logic [AW+15:0]    wr_q[$];
    logic [7:0]        exp_reply;
    logic              exp_loaded = 1'b0;

    always @(negedge clk) if (rom_we === 1'b1) wr_q.push_back({rom_addr, rom_wdata});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic build_frame(input int len, input bit corrupt);
        logic [15:0] l;
        logic [7:0]  x;
        l = 16'(len);
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(l[15:8]);
        frame_q.push_back(l[7:0]);
        for (int i = 0; i < 2 * len; i++) frame_q.push_back(8'($urandom_range(0, 255)));
        x = 8'h00;
        for (int i = 1; i < frame_q.size(); i++) x ^= frame_q[i];
        if (corrupt) x ^= 8'($urandom_range(1, 255));
        frame_q.push_back(x);
    endtask

    // Frame-level expectation: which words land where, and which reply byte comes back.
    task automatic model_frame();
        int         len;
        logic [7:0] x;
        exp_wr.delete();
        len = int'({frame_q[1], frame_q[2]});
        if (len > (1 << AW)) begin
            exp_reply = 8'h45;
            return;
        end
        for (int i = 0; i < len; i++)
            exp_wr.push_back({AW'(i), frame_q[3 + 2 * i], frame_q[4 + 2 * i]});
        x = 8'h00;
        for (int i = 1; i < frame_q.size() - 1; i++) x ^= frame_q[i];
        exp_reply = (x == frame_q[frame_q.size() - 1]) ? 8'h4B : 8'h45;
    endtask

    task automatic run_frame(input int hold, input int max_gap, input bit inject);
        logic [7:0] held;
        logic       ok;
        int         n;
        wr_q.delete();
        model_frame();
        n = frame_q.size();
        for (int i = 0; i < n; i++) begin
            send_byte(frame_q[i], (i == n - 1) ? 0 : int'($urandom_range(0, max_gap)));
            if (i == 0) begin
                vectors++;
                if (cpu_reset !== 1'b1 || busy !== 1'b1 || error !== 1'b0) begin
                    miscompares++;
                    $display("FAIL sync_entry: cpu_reset=%b busy=%b error=%b, required 1 1 0",
                             cpu_reset, busy, error);
                end
            end
        end
        vectors++;
        if (tx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reply_rise: tx_valid=%b one cycle after last byte, required 1", tx_valid);
        end
        for (int k = 0; k < 50 && tx_valid !== 1'b1; k++) tick();
        vectors++;
        if (tx_data !== exp_reply) begin
            miscompares++;
            $display("FAIL reply_byte: tx_data=%h, required %h", tx_data, exp_reply);
        end
        held = tx_data;
        for (int c = 0; c < hold; c++) begin
            if (inject && c == hold / 2) begin
                rx_valid = 1'b1;
                rx_data  = 8'hA5;
            end
            tick();
            rx_valid = 1'b0;
            vectors++;
            if (tx_valid !== 1'b1 || tx_data !== held || cpu_reset !== 1'b1 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL reply_hold: cycle %0d tx_valid=%b tx_data=%h cpu_reset=%b busy=%b, required 1 %h 1 1",
                         c, tx_valid, tx_data, cpu_reset, busy, held);
            end
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        ok = (exp_reply == 8'h4B);
        if (ok) exp_loaded = 1'b1;
        vectors++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || cpu_reset !== !ok) begin
            miscompares++;
            $display("FAIL after_handshake: tx_valid=%b busy=%b cpu_reset=%b, required 0 0 %b",
                     tx_valid, busy, cpu_reset, !ok);
        end
        vectors++;
        if (error !== !ok || loaded !== exp_loaded) begin
            miscompares++;
            $display("FAIL flags: error=%b loaded=%b, required %b %b", error, loaded, !ok, exp_loaded);
        end
        vectors++;
        if (wr_q.size() != exp_wr.size()) begin
            miscompares++;
            $display("FAIL write_count: %0d writes, required %0d", wr_q.size(), exp_wr.size());
        end
        for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) begin
            vectors++;
            if (wr_q[i] !== exp_wr[i]) begin
                miscompares++;
                $display("FAIL write_%0d: addr/data=%h, required %h", i, wr_q[i], exp_wr[i]);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        vectors++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || rom_we !== 1'b0 || rom_addr !== '0 ||
            rom_wdata !== 16'h0000 || busy !== 1'b0 || loaded !== 1'b0 || error !== 1'b0 ||
            cpu_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: txv=%b txd=%h we=%b addr=%h wd=%h busy=%b loaded=%b error=%b cpu_reset=%b, required 0 00 0 0 0000 0 0 0 1",
                     tag, tx_valid, tx_data, rom_we, rom_addr, rom_wdata, busy, loaded, error, cpu_reset);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        check_reset_values("reset_values");
        reset = 1'b0;
        tick();
        exp_loaded = 1'b0;
        vectors++;
        if (cpu_reset !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: cpu_reset=%b busy=%b, required 0 0", cpu_reset, busy);
        end
    endtask

    task automatic test_noise();
        wr_q.delete();
        send_byte(8'h41, 0);
        send_byte(8'h42, 2);
        vectors++;
        if (cpu_reset !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0 || wr_q.size() != 0) begin
            miscompares++;
            $display("FAIL noise: cpu_reset=%b busy=%b tx_valid=%b writes=%0d, required 0 0 0 0",
                     cpu_reset, busy, tx_valid, wr_q.size());
        end
    endtask

    task automatic test_good_load();
        frame_q = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_frame(2, 3, 1'b0);
    endtask

    task automatic test_bad_checksum();
        frame_q = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        run_frame(1, 3, 1'b0);
        frame_q = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_frame(0, 3, 1'b0);
    endtask

    task automatic test_timeout();
        int k;
        bit busy_drop;
        wr_q.delete();
        send_byte(8'hA5, int'($urandom_range(0, 3)));
        send_byte(8'h00, int'($urandom_range(0, 3)));
        send_byte(8'h01, int'($urandom_range(0, 3)));
        send_byte(8'h12, 0);
        k = 0;
        busy_drop = 1'b0;
        while (tx_valid !== 1'b1 && k < 3 * TMO) begin
            tick();
            k++;
            if (busy !== 1'b1) busy_drop = 1'b1;
        end
        vectors++;
        if (k != TMO) begin
            miscompares++;
            $display("FAIL timeout_latency: tx_valid after %0d cycles, required %0d", k, TMO);
        end
        vectors++;
        if (tx_data !== 8'h45 || busy_drop || wr_q.size() != 0) begin
            miscompares++;
            $display("FAIL timeout_reply: tx_data=%h busy_dropped=%b writes=%0d, required 45 0 0",
                     tx_data, busy_drop, wr_q.size());
        end
        repeat (3) tick();
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        vectors++;
        if (busy !== 1'b0 || cpu_reset !== 1'b1 || error !== 1'b1 || tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_halt: busy=%b cpu_reset=%b error=%b tx_valid=%b, required 0 1 1 0",
                     busy, cpu_reset, error, tx_valid);
        end
    endtask

    task automatic test_length_bounds();
        frame_q = {8'hA5, 8'h00, 8'h11};
        run_frame(1, 2, 1'b0);
        build_frame(16, 1'b0);
        run_frame(1, 2, 1'b0);
        frame_q = {8'hA5, 8'h00, 8'h00, 8'h00};
        run_frame(0, 2, 1'b0);
    endtask

    task automatic test_backpressure();
        build_frame(3, 1'b0);
        run_frame(20, 3, 1'b1);
    endtask

    task automatic test_back_to_back();
        build_frame(5, 1'b0);
        run_frame(1, 0, 1'b0);
        build_frame(2, 1'b1);
        run_frame(0, 0, 1'b0);
    endtask

    task automatic test_reset_midload();
        wr_q.delete();
        send_byte(8'hA5, int'($urandom_range(0, 2)));
        send_byte(8'h00, int'($urandom_range(0, 2)));
        send_byte(8'h04, int'($urandom_range(0, 2)));
        send_byte(8'h12, int'($urandom_range(0, 2)));
        send_byte(8'h34, 0);
        reset = 1'b1;
        tick();
        check_reset_values("midload_reset_values");
        reset = 1'b0;
        tick();
        exp_loaded = 1'b0;
        vectors++;
        if (cpu_reset !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midload_release: cpu_reset=%b busy=%b, required 0 0", cpu_reset, busy);
        end
        send_byte(8'h56, 0);
        send_byte(8'h78, 1);
        send_byte(8'h9A, 0);
        send_byte(8'hBC, 2);
        vectors++;
        if (wr_q.size() != 1 || wr_q[0] !== {AW'(0), 16'h1234} || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midload_writes: writes=%0d busy=%b, required 1 write of 0:1234 and busy 0",
                     wr_q.size(), busy);
        end
        build_frame(4, 1'b0);
        run_frame(1, 3, 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 12; f++) begin
            build_frame(int'($urandom_range(0, 16)), ($urandom_range(0, 3) == 0));
            run_frame(int'($urandom_range(0, 4)), 3, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_noise();
        test_good_load();
        test_bad_checksum();
        test_timeout();
        test_length_bounds();
        test_backpressure();
        test_back_to_back();
        test_reset_midload();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
